// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input conditioner:
// register offsets and the peripheral bus command encoding.
package gpio_in_pkg;

    localparam logic [1:0] REG_LEVEL   = 2'b00;
    localparam logic [1:0] REG_PENDING = 2'b01;
    localparam logic [1:0] REG_RISE_EN = 2'b10;
    localparam logic [1:0] REG_FALL_EN = 2'b11;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_BOTH  = 2'b11
    } bus_cmd_e;

    function automatic bus_cmd_e bus_cmd(input logic rd, input logic wr);
        return bus_cmd_e'({wr, rd});
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One-bit synchroniser and debouncer with single-cycle
// rise/fall pulses aligned to the filtered-level change.
module gpio_in_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [7:0]             cnt;
    logic                   f;
    logic                   s;
    logic                   flip;

    assign s    = sync[SYNC_STAGES-1];
    assign flip = (s != f) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            f    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (s == f) begin
                cnt <= '0;
            end else if (flip) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Pulses are decoded from the flop state so the pending
    // bit can be set on the same edge that f changes.
    assign level = f;
    assign rise  = flip && s;
    assign fall  = flip && !s;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Memory-mapped pad input conditioner: per-bit filter array,
// edge enables, write-1-to-clear pending bits and level irq.
module gpio_input_conditioner
    import gpio_in_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] gpios_in,
    output logic             irq
);

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       sel;
    bus_cmd_e         cmd;
    logic             rd_en;
    logic             wr_en;
    logic             unused;

    assign cmd   = bus_cmd(read, write);
    assign rd_en = (cmd == CMD_READ) || (cmd == CMD_BOTH);
    assign wr_en = (cmd == CMD_WRITE) || (cmd == CMD_BOTH);
    assign sel   = address[3:2];
    assign wdata = write_data[WIDTH-1:0];

    assign unused = ^{address[31:4], address[1:0],
                      write_data[31:WIDTH]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_filter
        gpio_in_filter #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_filter (
            .clk  (clk),
            .reset(reset),
            .pin  (pins_in[i]),
            .level(gpios_in[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign set = (rise & rise_en) | (fall & fall_en);
    assign clr = (wr_en && sel == REG_PENDING) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en <= '0;
            fall_en <= '0;
            pending <= '0;
        end else begin
            if (wr_en && sel == REG_RISE_EN) rise_en <= wdata;
            if (wr_en && sel == REG_FALL_EN) fall_en <= wdata;
            // A capture in the same cycle as its clear wins.
            pending <= (pending & ~clr) | set;
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (rd_en) begin
            unique case (sel)
                REG_LEVEL:   read_data = 32'(gpios_in);
                REG_PENDING: read_data = 32'(pending);
                REG_RISE_EN: read_data = 32'(rise_en);
                REG_FALL_EN: read_data = 32'(fall_en);
                default:     read_data = 32'h0;
            endcase
        end
    end

    assign irq = |pending;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner
// with default parameters (8 pins, 2 sync stages, limit 4).
module tb_gpio_input_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  pins_in;
    logic [7:0]  gpios_in;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    gpio_input_conditioner dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .pins_in   (pins_in),
        .gpios_in  (gpios_in),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        read    = 1'b1;
        address = {28'h0, a, 2'b00};
        #1;
        d       = read_data;
        read    = 1'b0;
        address = 32'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        write      = 1'b1;
        address    = {28'h0, a, 2'b00};
        write_data = d;
        @(posedge clk);
        #1;
        write      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
    endtask

    initial begin
        logic [31:0] d;
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        pins_in    = 8'h00;
        tick(2);
        reset = 1'b0;

        // Reset state
        rd(2'b00, d); check("rst_level", d, 32'h0);
        rd(2'b01, d); check("rst_pending", d, 32'h0);
        rd(2'b10, d); check("rst_rise_en", d, 32'h0);
        rd(2'b11, d); check("rst_fall_en", d, 32'h0);
        check("rst_gpios", {24'h0, gpios_in}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // Latency: change after edge N+5, not before
        tick(1);
        pins_in = 8'h01;
        tick(5);
        check("lat_before", {24'h0, gpios_in}, 32'h0);
        tick(1);
        check("lat_after", {24'h0, gpios_in}, 32'h1);
        rd(2'b00, d); check("lat_level", d, 32'h1);
        check("lat_irq", {31'h0, irq}, 32'h0);

        // Return low, then enable rising edges on bit 0
        pins_in = 8'h00;
        tick(8);
        check("low_gpios", {24'h0, gpios_in}, 32'h0);
        wr(2'b10, 32'h1);
        rd(2'b10, d); check("rise_en_rd", d, 32'h1);
        rd(2'b01, d); check("no_pend", d, 32'h0);

        // 3-cycle glitch is filtered out
        pins_in = 8'h01;
        tick(3);
        pins_in = 8'h00;
        tick(8);
        check("glitch_gpios", {24'h0, gpios_in}, 32'h0);
        rd(2'b01, d); check("glitch_pend", d, 32'h0);

        // Held high captures a rising edge
        pins_in = 8'h01;
        tick(5);
        check("rise_irq_early", {31'h0, irq}, 32'h0);
        tick(1);
        check("rise_gpios", {24'h0, gpios_in}, 32'h1);
        rd(2'b01, d); check("rise_pend", d, 32'h1);
        check("rise_irq", {31'h0, irq}, 32'h1);

        // Clear bit 0, then capture a falling edge on bit 7
        wr(2'b01, 32'h1);
        rd(2'b01, d); check("w1c0_pend", d, 32'h0);
        check("w1c0_irq", {31'h0, irq}, 32'h0);
        wr(2'b11, 32'h80);
        rd(2'b11, d); check("fall_en_rd", d, 32'h80);
        pins_in = 8'h81;
        tick(6);
        check("b7_high", {24'h0, gpios_in}, 32'h81);
        rd(2'b01, d); check("b7_rise_nopend", d, 32'h0);
        pins_in = 8'h01;
        tick(6);
        check("b7_low", {24'h0, gpios_in}, 32'h01);
        rd(2'b01, d); check("fall_pend", d, 32'h80);
        check("fall_irq", {31'h0, irq}, 32'h1);
        wr(2'b01, 32'h0);
        rd(2'b01, d); check("w0_noeffect", d, 32'h80);
        wr(2'b01, 32'h80);
        rd(2'b01, d); check("w1c7_pend", d, 32'h0);
        check("w1c7_irq", {31'h0, irq}, 32'h0);
        rd(2'b00, d); check("level_rd", d, 32'h1);
        wr(2'b00, 32'hFF);
        rd(2'b00, d); check("level_ro", d, 32'h1);

        // Set wins over a simultaneous W1C
        pins_in = 8'h00;
        tick(6);
        check("b0_low", {24'h0, gpios_in}, 32'h0);
        rd(2'b01, d); check("b0_fall_nopend", d, 32'h0);
        pins_in = 8'h01;
        tick(5);
        wr(2'b01, 32'h1);
        check("race_gpios", {24'h0, gpios_in}, 32'h1);
        rd(2'b01, d); check("race_pend", d, 32'h1);
        check("race_irq", {31'h0, irq}, 32'h1);

        // Clearing an enable keeps pending
        wr(2'b10, 32'h0);
        rd(2'b01, d); check("en_clr_pend", d, 32'h1);
        wr(2'b10, 32'h3);
        pins_in = 8'h03;
        tick(6);
        rd(2'b01, d); check("pend_03", d, 32'h3);

        // Reset mid-debounce on bit 2 (cnt = 2)
        pins_in = 8'h07;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mr_gpios", {24'h0, gpios_in}, 32'h0);
        check("mr_irq", {31'h0, irq}, 32'h0);
        rd(2'b01, d); check("mr_pend", d, 32'h0);
        rd(2'b10, d); check("mr_rise_en", d, 32'h0);
        rd(2'b11, d); check("mr_fall_en", d, 32'h0);
        tick(5);
        check("mr_refilter_early", {24'h0, gpios_in}, 32'h0);
        tick(1);
        check("mr_refilter", {24'h0, gpios_in}, 32'h07);
        rd(2'b01, d); check("mr_refilter_pend", d, 32'h0);
        check("mr_refilter_irq", {31'h0, irq}, 32'h0);
        check("idle_rdata", read_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
